// File: rtl/ram_init_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_init_pkg
// Description : Shared enums for the self-initialising RAM and its init engine
// Revision    : 3.0 - parametrised successor of the fixed 16x4 initialised RAM
// ============================================================================
package ram_init_pkg;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } rd_mode_e;

    typedef enum logic [0:0] {
        INIT_CONST = 1'b0,
        INIT_ADDR  = 1'b1
    } init_mode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } init_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : ram_init_seq
// Description : Init FSM and address counter; walks every word once per run
// Revision    : 3.0 - parametrised depth/width, address or constant pattern
// ============================================================================
module ram_init_seq
    import ram_init_pkg::*;
#(
    parameter int                DATA_W        = 8,
    parameter int                DEPTH         = 16,
    parameter int                ADDR_W        = $clog2(DEPTH),
    parameter init_mode_e        INIT_MODE     = INIT_CONST,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
    parameter bit                INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    init_state_e       r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] w_pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT_ON_RESET ? INIT : IDLE;
            r_cnt   <= '0;
            r_busy  <= INIT_ON_RESET;
        end else begin
            case (r_state)
                IDLE: begin
                    if (init_req) begin
                        r_state <= INIT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                INIT: begin
                    // Requests arriving mid-run are dropped, not queued.
                    if (r_cnt == c_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    if (DATA_W > ADDR_W) begin : g_pat_zext
        assign w_pat = {{(DATA_W - ADDR_W){1'b0}}, r_cnt};
    end else begin : g_pat_trunc
        assign w_pat = r_cnt[DATA_W-1:0];
    end

    assign init_busy = r_busy;
    assign init_we   = (r_state == INIT);
    assign init_addr = r_cnt;
    assign init_data = (INIT_MODE == INIT_ADDR) ? w_pat : INIT_VALUE;

endmodule
`default_nettype wire

// File: rtl/ram_init_v3.sv
`default_nettype none
// ============================================================================
// Module      : ram_init_v3
// Description : Single-port sync RAM with hardware init engine, selectable
//               read-during-write mode, optional output register
// Revision    : 3.0 - adds RD_MODE, OUT_REG, range check and valid signalling
// ============================================================================
module ram_init_v3
    import ram_init_pkg::*;
#(
    parameter int                DATA_W        = 8,
    parameter int                DEPTH         = 16,
    parameter int                ADDR_W        = $clog2(DEPTH),
    parameter rd_mode_e          RD_MODE       = WRITE_FIRST,
    parameter int                OUT_REG       = 0,
    parameter init_mode_e        INIT_MODE     = INIT_CONST,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
    parameter bit                INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              init_busy,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic [DATA_W-1:0] w_init_data;
    logic              w_accept;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rd_data;

    logic [DATA_W-1:0] r_dout1;
    logic              r_valid1;
    logic              r_err1;

    ram_init_seq #(
        .DATA_W        (DATA_W),
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W),
        .INIT_MODE     (INIT_MODE),
        .INIT_VALUE    (INIT_VALUE),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .init_busy (w_busy),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .init_data (w_init_data)
    );

    assign init_busy  = w_busy;
    assign w_accept   = en & ~w_busy & ~rst;
    assign w_in_range = ({1'b0, addr} < c_DEPTH);
    // Out-of-range locations read as zero rather than aliasing another word.
    assign w_rd_data  = w_in_range ? r_mem[addr] : '0;

    // The engine and user accesses never compete: acceptance requires !busy.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= w_init_data;
        end else if (w_accept && we && w_in_range) begin
            r_mem[addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout1  <= '0;
            r_valid1 <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_valid1 <= 1'b0;
            r_err1   <= 1'b0;
            if (w_accept) begin
                r_err1 <= ~w_in_range;
                if (!we) begin
                    r_dout1  <= w_rd_data;
                    r_valid1 <= 1'b1;
                end else if (RD_MODE == WRITE_FIRST) begin
                    r_dout1  <= w_in_range ? din : '0;
                    r_valid1 <= 1'b1;
                end else if (RD_MODE == READ_FIRST) begin
                    r_dout1  <= w_rd_data;
                    r_valid1 <= 1'b1;
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] r_dout2;
        logic              r_valid2;
        logic              r_err2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout2  <= '0;
                r_valid2 <= 1'b0;
                r_err2   <= 1'b0;
            end else begin
                r_dout2  <= r_dout1;
                r_valid2 <= r_valid1;
                r_err2   <= r_err1;
            end
        end

        assign dout       = r_dout2;
        assign dout_valid = r_valid2;
        assign addr_err   = r_err2;
    end else begin : g_out_comb
        assign dout       = r_dout1;
        assign dout_valid = r_valid1;
        assign addr_err   = r_err1;
    end

endmodule
`default_nettype wire

// File: doc/ram_init_v3.md
Name: ram_init_v3

Overview:
- Parametrised single-port synchronous RAM with a built-in hardware initialisation engine; successor to the fixed 16x4 initialised RAM.
- After reset, or on request, the engine walks every address and writes a constant or address pattern. User accesses are blocked while it runs.
- Adds selectable read-during-write mode, an optional output register, out-of-range address detection and valid signalling.
- Sits as a generic storage primitive under table/LUT and scratchpad logic.

Parameters:
- DATA_W, 8: data width in bits (>=1).
- DEPTH, 16: number of words (>=2, need not be a power of 2).
- ADDR_W, $clog2(DEPTH): address width.
- RD_MODE, WRITE_FIRST: read-during-write mode, one of WRITE_FIRST, READ_FIRST, NO_CHANGE.
- OUT_REG, 0: 1 adds an output pipeline register (read latency 2 instead of 1).
- INIT_MODE, INIT_CONST: INIT_CONST writes INIT_VALUE; INIT_ADDR writes the address, zero-extended or truncated to DATA_W.
- INIT_VALUE, '0: constant used by INIT_CONST.
- INIT_ON_RESET, 1: 1 starts initialisation automatically when reset deasserts.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- init_req, in, 1: single-cycle request to re-initialise the whole memory.
- init_busy, out, 1: high while the init engine owns the memory.
- en, in, 1: access enable.
- we, in, 1: write enable, qualified by en.
- addr, in, ADDR_W: access address.
- din, in, DATA_W: write data.
- dout, out, DATA_W: read data.
- dout_valid, out, 1: dout updated by an accepted access this cycle.
- addr_err, out, 1: pulse for an accepted access with addr >= DEPTH.

Behaviour:
- Reset values: dout=0, dout_valid=0, addr_err=0, init counter=0, FSM=INIT if INIT_ON_RESET else IDLE, init_busy=INIT_ON_RESET. Memory contents are not reset.
- FSM states: IDLE, INIT.
- INIT state:
  - Each cycle writes pattern(cnt) to mem[cnt], then cnt++.
  - The cycle writing cnt==DEPTH-1 transitions to IDLE.
  - init_busy deasserts the following cycle. Exactly DEPTH busy cycles after rst falls.
- IDLE state: init_req=1 moves to INIT next cycle with cnt=0. init_req is ignored while in INIT (no queueing).
- Access acceptance: an access is accepted when en=1 and FSM=IDLE. While busy, en/we/addr/din are ignored: no write, dout holds, dout_valid=0, addr_err=0.
- Simultaneous init_req and en in IDLE: the access is accepted and completes normally; init starts the next cycle. Under OUT_REG=1 the in-flight read still emerges with dout_valid.
- Read (en=1, we=0): dout=mem[addr], dout_valid=1 at latency 1+OUT_REG.
- Write (en=1, we=1): mem[addr]<=din. dout depends on RD_MODE:
  - WRITE_FIRST: dout=din, valid=1.
  - READ_FIRST: dout=old mem[addr], valid=1.
  - NO_CHANGE: dout holds, valid=0.
- No valid access: dout holds its last value; dout_valid=0.
- addr >= DEPTH (only possible when DEPTH is not a power of 2):
  - Write is dropped.
  - A read returns 0 with valid=1.
  - addr_err pulses aligned with dout_valid timing (latency 1+OUT_REG).
- OUT_REG=1: dout, dout_valid and addr_err all pass through one extra register stage. Fully pipelined, one access per cycle.
- rst mid-init: FSM restarts per INIT_ON_RESET with cnt=0, so the full DEPTH-cycle init repeats. rst also clears output pipeline contents.
- Width rules:
  - INIT_ADDR pattern = cnt zero-extended when DATA_W>ADDR_W, low DATA_W bits otherwise.
  - Counter is ADDR_W bits and never exceeds DEPTH-1.

Decomposition:
- Package ram_init_pkg holds:
  - enum rd_mode_e {WRITE_FIRST, READ_FIRST, NO_CHANGE}
  - enum init_mode_e {INIT_CONST, INIT_ADDR}
  - enum init_state_e {IDLE, INIT}
- Sub-module ram_init_seq: init FSM plus counter. Outputs init_busy, init_we, init_addr, init_data. The top level muxes these against user accesses and owns the array and output pipeline.

Test Plan (DATA_W=8, DEPTH=16 unless stated):
- INIT_ADDR, INIT_ON_RESET=1, release rst -> init_busy high exactly 16 cycles. Reads of addr 0..15 then return 0x00..0x0F at latency 1 with dout_valid=1.
- WRITE_FIRST: write 0xA5 to addr 3 -> next cycle dout=0xA5, valid=1. READ_FIRST on the same data -> dout=0x03. NO_CHANGE -> dout holds, valid=0. A subsequent read of addr 3 returns 0xA5.
- INIT_CONST, INIT_VALUE=0x5A: write 0x11 to addr 7, pulse init_req -> 16 busy cycles; en=1 reads issued during busy give dout_valid=0. Afterwards addr 7 reads 0x5A.
- DEPTH=12: write 0xFF to addr 13 -> addr_err pulse, mem unchanged. Read addr 13 -> dout=0x00, valid=1, addr_err=1. Read addr 11 -> 0x0B (INIT_ADDR).
- Assert rst at init cycle 7, release -> counter restarts at 0, busy a full 16 cycles, all addresses correctly initialised.
- OUT_REG=1: back-to-back reads of addr 0,1,2 -> dout 0x00,0x01,0x02 on consecutive cycles starting 2 cycles after the first request. Read issued together with init_req still returns valid data.
